// File: rtl/id_ex_issue_reg.sv
// rtl/id_ex_issue_reg.sv - ID/EX issue register with load-use hazard detection and event counters
//
// Purpose:
//   Captures the decode-stage instruction (control bundle, operands, indices)
//   each cycle and presents it to EX. Detects a load-use hazard against the
//   EX slot, inserts a single bubble and holds PC / IF/ID while it does so.
//   A decode-stage squash (flush) captures a bubble; a downstream hold
//   (ex_hold) freezes the whole register. Saturating counters record stall
//   and flush events.
//
// Ports:
//   clk, reset                      clock (rising edge), async active-high reset
//   id_valid, id_pc                 ID slot valid flag and PC
//   id_rs1data, id_rs2data, id_imm  ID operands
//   id_rd, id_rs1, id_rs2           register indices
//   id_rs1_used, id_rs2_used        source operand actually read
//   id_ctrl[19:0]                   packed control bundle
//   flush                           squash the ID instruction
//   ex_hold                         freeze this register
//   stall_if_id                     hold PC and IF/ID this cycle
//   ex_*                            registered EX-slot copies
//   stall_cnt, flush_cnt            saturating event counters

module id_ex_issue_reg #(
  parameter int XLEN        = 32,
  parameter int RFIDX_WIDTH = 5,
  parameter int CNT_W       = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   id_valid,
  input  logic [XLEN-1:0]        id_pc,
  input  logic [XLEN-1:0]        id_rs1data,
  input  logic [XLEN-1:0]        id_rs2data,
  input  logic [XLEN-1:0]        id_imm,
  input  logic [RFIDX_WIDTH-1:0] id_rd,
  input  logic [RFIDX_WIDTH-1:0] id_rs1,
  input  logic [RFIDX_WIDTH-1:0] id_rs2,
  input  logic                   id_rs1_used,
  input  logic                   id_rs2_used,
  input  logic [19:0]            id_ctrl,
  input  logic                   flush,
  input  logic                   ex_hold,
  output logic                   stall_if_id,
  output logic                   ex_valid,
  output logic [XLEN-1:0]        ex_pc,
  output logic [XLEN-1:0]        ex_rs1data,
  output logic [XLEN-1:0]        ex_rs2data,
  output logic [XLEN-1:0]        ex_imm,
  output logic [RFIDX_WIDTH-1:0] ex_rd,
  output logic [RFIDX_WIDTH-1:0] ex_rs1,
  output logic [RFIDX_WIDTH-1:0] ex_rs2,
  output logic [19:0]            ex_ctrl,
  output logic [CNT_W-1:0]       stall_cnt,
  output logic [CNT_W-1:0]       flush_cnt
);

  localparam int CTRL_MEMTOREG = 3;

  logic                   valid_q,   valid_d;
  logic [XLEN-1:0]        pc_q,      pc_d;
  logic [XLEN-1:0]        rs1data_q, rs1data_d;
  logic [XLEN-1:0]        rs2data_q, rs2data_d;
  logic [XLEN-1:0]        imm_q,     imm_d;
  logic [RFIDX_WIDTH-1:0] rd_q,      rd_d;
  logic [RFIDX_WIDTH-1:0] rs1_q,     rs1_d;
  logic [RFIDX_WIDTH-1:0] rs2_q,     rs2_d;
  logic [19:0]            ctrl_q,    ctrl_d;
  logic [CNT_W-1:0]       stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]       flush_cnt_q, flush_cnt_d;

  logic load_use;
  logic capture_bubble;
  logic stall_event;
  logic flush_event;

  // Only the EX slot is checked; the EX->MEM distance is forwarded elsewhere.
  // An EX destination of x0 never creates a hazard.
  assign load_use = valid_q & ctrl_q[CTRL_MEMTOREG] & (rd_q != '0) & id_valid &
                    ((id_rs1_used & (id_rs1 == rd_q)) |
                     (id_rs2_used & (id_rs2 == rd_q)));

  // Hold wins outright, so flush cannot release a held pipeline front end.
  assign stall_if_id = ex_hold | (~flush & load_use);

  assign stall_event    = ~ex_hold & ~flush & load_use;
  assign flush_event    = ~ex_hold & flush & id_valid;
  assign capture_bubble = flush | load_use | ~id_valid;

  always_comb begin
    valid_d     = valid_q;
    pc_d        = pc_q;
    rs1data_d   = rs1data_q;
    rs2data_d   = rs2data_q;
    imm_d       = imm_q;
    rd_d        = rd_q;
    rs1_d       = rs1_q;
    rs2_d       = rs2_q;
    ctrl_d      = ctrl_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;

    if (!ex_hold) begin
      if (capture_bubble) begin
        // A bubble clears everything so a dead slot can never write memory or
        // the register file, and carries no stale operands.
        valid_d   = 1'b0;
        pc_d      = '0;
        rs1data_d = '0;
        rs2data_d = '0;
        imm_d     = '0;
        rd_d      = '0;
        rs1_d     = '0;
        rs2_d     = '0;
        ctrl_d    = '0;
      end else begin
        valid_d   = 1'b1;
        pc_d      = id_pc;
        rs1data_d = id_rs1data;
        rs2data_d = id_rs2data;
        imm_d     = id_imm;
        rd_d      = id_rd;
        rs1_d     = id_rs1;
        rs2_d     = id_rs2;
        ctrl_d    = id_ctrl;
      end

      if (stall_event && !(&stall_cnt_q)) begin
        stall_cnt_d = stall_cnt_q + 1'b1;
      end
      if (flush_event && !(&flush_cnt_q)) begin
        flush_cnt_d = flush_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q     <= 1'b0;
      pc_q        <= '0;
      rs1data_q   <= '0;
      rs2data_q   <= '0;
      imm_q       <= '0;
      rd_q        <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      ctrl_q      <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      valid_q     <= valid_d;
      pc_q        <= pc_d;
      rs1data_q   <= rs1data_d;
      rs2data_q   <= rs2data_d;
      imm_q       <= imm_d;
      rd_q        <= rd_d;
      rs1_q       <= rs1_d;
      rs2_q       <= rs2_d;
      ctrl_q      <= ctrl_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign ex_valid   = valid_q;
  assign ex_pc      = pc_q;
  assign ex_rs1data = rs1data_q;
  assign ex_rs2data = rs2data_q;
  assign ex_imm     = imm_q;
  assign ex_rd      = rd_q;
  assign ex_rs1     = rs1_q;
  assign ex_rs2     = rs2_q;
  assign ex_ctrl    = ctrl_q;
  assign stall_cnt  = stall_cnt_q;
  assign flush_cnt  = flush_cnt_q;

endmodule

// File: tb/tb_id_ex_issue_reg.sv
// tb/tb_id_ex_issue_reg.sv - directed self-checking bench for id_ex_issue_reg
module tb_id_ex_issue_reg;

  localparam int XLEN  = 32;
  localparam int RW    = 5;
  localparam int CNT_W = 4;

  localparam logic [19:0] C_LW   = 20'h0000C; // memtoreg | regwrite
  localparam logic [19:0] C_ADDI = 20'h10004; // aluctrl=1, regwrite
  localparam logic [19:0] C_ADD  = 20'h00004; // regwrite

  logic            clk = 1'b0;
  logic            reset;
  logic            id_valid;
  logic [XLEN-1:0] id_pc, id_rs1data, id_rs2data, id_imm;
  logic [RW-1:0]   id_rd, id_rs1, id_rs2;
  logic            id_rs1_used, id_rs2_used;
  logic [19:0]     id_ctrl;
  logic            flush, ex_hold;
  logic            stall_if_id, ex_valid;
  logic [XLEN-1:0] ex_pc, ex_rs1data, ex_rs2data, ex_imm;
  logic [RW-1:0]   ex_rd, ex_rs1, ex_rs2;
  logic [19:0]     ex_ctrl;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  id_ex_issue_reg #(.XLEN(XLEN), .RFIDX_WIDTH(RW), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .id_valid(id_valid), .id_pc(id_pc),
    .id_rs1data(id_rs1data), .id_rs2data(id_rs2data), .id_imm(id_imm),
    .id_rd(id_rd), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .id_ctrl(id_ctrl), .flush(flush), .ex_hold(ex_hold),
    .stall_if_id(stall_if_id), .ex_valid(ex_valid), .ex_pc(ex_pc),
    .ex_rs1data(ex_rs1data), .ex_rs2data(ex_rs2data), .ex_imm(ex_imm),
    .ex_rd(ex_rd), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_ctrl(ex_ctrl),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic v, input logic [XLEN-1:0] pc, input logic [RW-1:0] rd,
                         input logic [RW-1:0] rs1, input logic [RW-1:0] rs2,
                         input logic u1, input logic u2, input logic [19:0] ctrl);
    id_valid    = v;
    id_pc       = pc;
    id_rs1data  = pc ^ 32'hA5A5_0000;
    id_rs2data  = pc ^ 32'h0000_5A5A;
    id_imm      = pc + 32'd1;
    id_rd       = rd;
    id_rs1      = rs1;
    id_rs2      = rs2;
    id_rs1_used = u1;
    id_rs2_used = u2;
    id_ctrl     = ctrl;
    #1;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; ex_hold = 1'b0;
    present(1'b0, '0, '0, '0, '0, 1'b0, 1'b0, '0);
    tick();
    chk("rst_ex_valid", ex_valid, 0);
    chk("rst_ex_ctrl", ex_ctrl, 0);
    chk("rst_ex_pc", ex_pc, 0);
    chk("rst_stall_cnt", stall_cnt, 0);
    chk("rst_flush_cnt", flush_cnt, 0);
    chk("rst_stall_if_id", stall_if_id, 0);
    reset = 1'b0;

    // addi x5 flows through in one cycle
    present(1'b1, 32'h100, 5'd5, 5'd0, 5'd0, 1'b1, 1'b0, C_ADDI);
    chk("addi_no_stall", stall_if_id, 0);
    tick();
    chk("addi_ex_valid", ex_valid, 1);
    chk("addi_ex_rd", ex_rd, 5);
    chk("addi_regwrite", ex_ctrl[2], 1);
    chk("addi_ex_ctrl", ex_ctrl, C_ADDI);
    chk("addi_ex_pc", ex_pc, 32'h100);
    chk("addi_ex_imm", ex_imm, 32'h101);
    chk("addi_ex_rs1data", ex_rs1data, 32'hA5A5_0100);

    // lw x6 reading x5: EX is not a load, so no hazard
    present(1'b1, 32'h104, 5'd6, 5'd5, 5'd0, 1'b1, 1'b0, C_LW);
    chk("lw_no_stall", stall_if_id, 0);
    tick();
    chk("lw_ex_rd", ex_rd, 6);
    chk("lw_ex_ctrl", ex_ctrl, C_LW);

    // add x7,x6,x1 behind lw x6: one bubble, then the add is captured
    present(1'b1, 32'h108, 5'd7, 5'd6, 5'd1, 1'b1, 1'b1, C_ADD);
    chk("lu_stall", stall_if_id, 1);
    tick();
    chk("lu_bubble_valid", ex_valid, 0);
    chk("lu_bubble_ctrl", ex_ctrl, 0);
    chk("lu_bubble_pc", ex_pc, 0);
    chk("lu_stall_cnt", stall_cnt, 1);
    chk("lu_release", stall_if_id, 0);
    tick();
    chk("lu_add_valid", ex_valid, 1);
    chk("lu_add_rd", ex_rd, 7);
    chk("lu_add_pc", ex_pc, 32'h108);
    chk("lu_stall_cnt_hold", stall_cnt, 1);

    // lw x0 in EX, ID reads x0: masked
    present(1'b1, 32'h10C, 5'd0, 5'd1, 5'd0, 1'b1, 1'b0, C_LW);
    tick();
    present(1'b1, 32'h110, 5'd6, 5'd0, 5'd0, 1'b1, 1'b1, C_LW);
    chk("x0_no_stall", stall_if_id, 0);
    tick();
    chk("x0_captured_pc", ex_pc, 32'h110);

    // lw x6 in EX, lui x6 with no sources used: no stall
    present(1'b1, 32'h114, 5'd6, 5'd6, 5'd6, 1'b0, 1'b0, C_ADD);
    chk("unused_no_stall", stall_if_id, 0);
    tick();
    chk("unused_ex_pc", ex_pc, 32'h114);
    chk("unused_stall_cnt", stall_cnt, 1);

    // id_valid=0 in the normal case is a bubble with no counting
    present(1'b0, 32'h200, 5'd9, 5'd0, 5'd0, 1'b0, 1'b0, C_ADD);
    tick();
    chk("inv_ex_valid", ex_valid, 0);
    chk("inv_ex_ctrl", ex_ctrl, 0);
    chk("inv_flush_cnt", flush_cnt, 0);

    // flush beats load-use
    present(1'b1, 32'h118, 5'd6, 5'd0, 5'd0, 1'b0, 1'b0, C_LW);
    tick();
    present(1'b1, 32'h11C, 5'd7, 5'd6, 5'd0, 1'b1, 1'b0, C_ADD);
    flush = 1'b1;
    #1;
    chk("fl_no_stall", stall_if_id, 0);
    tick();
    flush = 1'b0;
    chk("fl_ex_valid", ex_valid, 0);
    chk("fl_ex_ctrl", ex_ctrl, 0);
    chk("fl_flush_cnt", flush_cnt, 1);
    chk("fl_stall_cnt", stall_cnt, 1);

    // ex_hold beats flush for 3 cycles, then flush applies
    present(1'b1, 32'h120, 5'd5, 5'd0, 5'd0, 1'b1, 1'b0, C_ADDI);
    tick();
    present(1'b1, 32'h124, 5'd8, 5'd5, 5'd0, 1'b1, 1'b0, C_ADD);
    ex_hold = 1'b1; flush = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("hold_stall", stall_if_id, 1);
      tick();
      chk("hold_ex_valid", ex_valid, 1);
      chk("hold_ex_pc", ex_pc, 32'h120);
      chk("hold_ex_ctrl", ex_ctrl, C_ADDI);
      chk("hold_flush_cnt", flush_cnt, 1);
      chk("hold_stall_cnt", stall_cnt, 1);
    end
    ex_hold = 1'b0;
    #1;
    chk("hold_rel_stall", stall_if_id, 0);
    tick();
    flush = 1'b0;
    chk("hold_rel_valid", ex_valid, 0);
    chk("hold_rel_flush_cnt", flush_cnt, 2);

    // 20 load-use stalls saturate the 4-bit counter at 15
    for (int i = 0; i < 20; i++) begin
      present(1'b1, 32'h300, 5'd6, 5'd0, 5'd0, 1'b0, 1'b0, C_LW);
      tick();
      present(1'b1, 32'h304, 5'd7, 5'd6, 5'd0, 1'b1, 1'b0, C_ADD);
      tick();
      chk("sat_step", stall_cnt, ((2 + i) > 15) ? 15 : (2 + i));
    end
    chk("sat_final", stall_cnt, 15);

    // reset mid-stall takes effect before the next edge
    present(1'b1, 32'h308, 5'd6, 5'd0, 5'd0, 1'b0, 1'b0, C_LW);
    tick();
    present(1'b1, 32'h30C, 5'd7, 5'd6, 5'd0, 1'b1, 1'b0, C_ADD);
    chk("mid_stall", stall_if_id, 1);
    reset = 1'b1;
    #1;
    chk("mid_rst_stall", stall_if_id, 0);
    chk("mid_rst_valid", ex_valid, 0);
    chk("mid_rst_stall_cnt", stall_cnt, 0);
    chk("mid_rst_flush_cnt", flush_cnt, 0);
    tick();
    reset = 1'b0;
    #1;
    chk("post_rst_no_stall", stall_if_id, 0);
    tick();
    chk("post_rst_valid", ex_valid, 1);
    chk("post_rst_rd", ex_rd, 7);
    chk("post_rst_stall_cnt", stall_cnt, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/id_ex_issue_reg.md
Name: id_ex_issue_reg

Overview:
- ID/EX pipeline register that captures the decode-stage control bundle and operands each cycle and presents them to the EX stage.
- Contains the load-use hazard detector. On a hazard it inserts a bubble and stalls PC and IF/ID.
- Handles a decode-stage squash and a downstream hold.
- Provides saturating stall and flush event counters for performance debug.

Parameters:
- XLEN, 32, datapath width
- RFIDX_WIDTH, 5, register index width
- CNT_W, 16, event counter width

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous active-high reset
- id_valid  in  1  ID slot holds a real instruction
- id_pc  in  XLEN  PC of the ID instruction
- id_rs1data, id_rs2data  in  XLEN  register-file read data
- id_imm  in  XLEN  sign-extended immediate
- id_rd, id_rs1, id_rs2  in  RFIDX_WIDTH  register indices
- id_rs1_used, id_rs2_used  in  1  source operand is actually read
- id_ctrl  in  20  packed controller outputs (layout below)
- flush  in  1  squash the ID instruction (decode-stage redirect)
- ex_hold  in  1  downstream stall; freeze this register
- stall_if_id  out  1  hold PC and IF/ID this cycle
- ex_valid  out  1  EX slot holds a real instruction
- ex_pc, ex_rs1data, ex_rs2data, ex_imm  out  XLEN  registered copies
- ex_rd, ex_rs1, ex_rs2  out  RFIDX_WIDTH  registered copies
- ex_ctrl  out  20  registered control bundle
- stall_cnt, flush_cnt  out  CNT_W  event counters

Behaviour:
- id_ctrl / ex_ctrl packing, MSB to LSB:
  - [19:16] aluctrl
  - [15:13] aluctrl1
  - [12:11] alusrca
  - [10] alusrcb
  - [9] memwrite
  - [8] lunsigned
  - [7:6] lwhb
  - [5:4] swhb
  - [3] memtoreg
  - [2] regwrite
  - [1] j
  - [0] btype
- Reset (asynchronous, immediate): ex_valid=0; all ex_* fields =0; both counters =0. stall_if_id is combinational, so it reads 0 while ex_valid=0.
- load_use (combinational) = ex_valid & ex_ctrl[3] & (ex_rd!=0) & id_valid & ((id_rs1_used & id_rs1==ex_rd) | (id_rs2_used & id_rs2==ex_rd)).
- Per-cycle action, evaluated in this priority order:
  1. ex_hold=1: all registers keep their value; stall_if_id=1; no counter changes.
  2. flush=1: capture a bubble; stall_if_id=0. flush_cnt+1 if id_valid=1.
  3. load_use=1: capture a bubble; stall_if_id=1; stall_cnt+1. The ID instruction is re-presented next cycle.
  4. Otherwise: capture all id_* fields; ex_valid<=id_valid; stall_if_id=0.
- Bubble: ex_valid=0 and ex_ctrl=0, so memwrite and regwrite are 0. Datapath fields ex_pc…ex_rs2 are also cleared to 0.
- id_valid=0 in the normal case: captured as a bubble (ex_ctrl cleared). Neither counter increments.
- Latency: the ID instruction appears at ex_* one cycle after capture. A load-use pair costs exactly one bubble.
- Hazard detection compares only against the EX slot. The EX→MEM distance is covered by the forwarding unit, not by this block.
- x0 is never a hazard: ex_rd=0 masks the comparison.
- Counters saturate at all-ones and do not wrap.
- Reset asserted mid-stall: ex_valid and stall_if_id drop in the same cycle; the hazard does not persist after reset release.
- No state machine beyond the registered slot itself. stall_if_id must not depend on flush when ex_hold=1.

Test Plan:
- Reset then normal flow: assert reset, release. Present addi x5 (id_valid=1, rd=5, regwrite=1) → next cycle ex_valid=1, ex_rd=5, ex_ctrl[2]=1, stall_if_id=0.
- Load-use: EX holds lw x6 (memtoreg=1, rd=6). ID presents add x7,x6,x1 with rs1_used=1 → stall_if_id=1; next cycle ex_valid=0, ex_ctrl=0, stall_cnt=1. Following cycle the add is captured.
- x0 and unused-operand masking:
  - lw x0 in EX, ID reads x0 → no stall.
  - lw x6 in EX, ID lui x6 (rs1_used=0, rs2_used=0) → no stall.
- Flush beats load_use: hazard condition true and flush=1 in the same cycle → stall_if_id=0, bubble captured, flush_cnt=1, stall_cnt unchanged.
- ex_hold beats all: ex_hold=1 with flush=1 for 3 cycles → ex_* unchanged, stall_if_id=1, counters unchanged. After release, flush takes effect.
- Saturation and reset: CNT_W=4, force 20 load-use stalls → stall_cnt=15. Assert reset mid-stall → stall_cnt=0, ex_valid=0, stall_if_id=0 before the next clock edge.
